alu_writeback: RTL and testbench

Sequential commit stage directly downstream of the 8051 combinational ALU.
- Accepts one ALU result per handshake: the 4-bit opcode, 16-bit dest, CY, OX (aux carry) and OVF.
- Commits the result into the architectural ACC, B and PSW registers, or emits a 16-bit branch/address target for the address-arithmetic opcodes.
- Models the multi-cycle MUL/DIV occupancy with a stall counter.
- Exposes an SFR write port for direct PSW/ACC/B writes from the core.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_wb_muldiv_timer.sv | 36 +++
 rtl/alu_writeback.sv | 179 +++++++++++++++++
 tb/tb_alu_writeback.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared 8051 ALU encodings: opcodes, PSW bit positions and SFR write selects.
package alu_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ADD    = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_MUL    = 4'h3;
  localparam logic [3:0] OP_DIV    = 4'h4;
  localparam logic [3:0] OP_DA     = 4'h5;
  localparam logic [3:0] OP_ANL    = 4'h6;
  localparam logic [3:0] OP_ORL    = 4'h7;
  localparam logic [3:0] OP_XRL    = 4'h8;
  localparam logic [3:0] OP_CPL    = 4'h9;
  localparam logic [3:0] OP_RL     = 4'hA;
  localparam logic [3:0] OP_RLC    = 4'hB;
  localparam logic [3:0] OP_RR     = 4'hC;
  localparam logic [3:0] OP_RRC    = 4'hD;
  localparam logic [3:0] OP_ADDR11 = 4'hE;
  localparam logic [3:0] OP_ADDR16 = 4'hF;

  localparam int unsigned PSW_CY  = 7;
  localparam int unsigned PSW_AC  = 6;
  localparam int unsigned PSW_F0  = 5;
  localparam int unsigned PSW_RS1 = 4;
  localparam int unsigned PSW_RS0 = 3;
  localparam int unsigned PSW_OV  = 2;
  localparam int unsigned PSW_F1  = 1;
  localparam int unsigned PSW_P   = 0;

  localparam logic [1:0] SFR_ACC  = 2'b00;
  localparam logic [1:0] SFR_B    = 2'b01;
  localparam logic [1:0] SFR_PSW  = 2'b10;
  localparam logic [1:0] SFR_NONE = 2'b11;

endpackage

// File: rtl/alu_wb_muldiv_timer.sv
// MUL/DIV occupancy counter: loads MULDIV_LAT-1 on start and pulses done on the
// edge where it counts down to zero.
module alu_wb_muldiv_timer #(
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  localparam int unsigned CntW = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CntW'(MULDIV_LAT - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // done marks the edge on which the count moves 1 -> 0
  assign done = (cnt_q == CntW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// 8051 ALU commit stage: retires ALU results into ACC/B/PSW or a branch target,
// holds MUL/DIV for MULDIV_LAT cycles and merges direct SFR writes.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4,
  parameter logic [7:0]  RST_SP_PSW = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  opcode,
  input  logic [15:0] dest,
  input  logic        cy_in,
  input  logic        ox_in,
  input  logic        ovf_in,
  input  logic        sfr_we,
  input  logic [1:0]  sfr_sel,
  input  logic [7:0]  sfr_wdata,
  output logic [7:0]  acc,
  output logic [7:0]  b,
  output logic [7:0]  psw,
  output logic        busy,
  output logic        br_valid,
  output logic [15:0] br_target
);

  localparam bit MdMulti = (MULDIV_LAT > 1);

  typedef enum logic [0:0] {StIdle, StMdWait} state_e;

  state_e      state_q, state_d;
  logic [7:0]  acc_q, acc_d, b_q, b_d;
  logic [7:1]  psw_q, psw_d;  // P is derived from acc, never stored
  logic        br_valid_q, br_valid_d;
  logic [15:0] br_target_q, br_target_d;
  logic [3:0]  hold_op_q;
  logic [15:0] hold_dest_q;
  logic        hold_ovf_q;

  logic        accept, is_md, md_start, md_done;
  logic        commit, c_cy, c_ox, c_ovf;
  logic [3:0]  c_op;
  logic [15:0] c_dest;

  assign accept   = in_valid & in_ready;
  assign is_md    = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign md_start = accept & is_md & MdMulti;

  alu_wb_muldiv_timer #(
    .MULDIV_LAT(MULDIV_LAT)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .start(md_start),
    .done (md_done)
  );

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (md_start) state_d = StMdWait;
      end
      StMdWait: begin
        busy = 1'b1;
        if (md_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Commit source: live ALU result, or the held MUL/DIV result on its done edge
  always_comb begin
    commit = accept & ~md_start;
    c_op   = opcode;
    c_dest = dest;
    c_cy   = cy_in;
    c_ox   = ox_in;
    c_ovf  = ovf_in;
    if (state_q == StMdWait) begin
      commit = md_done;
      c_op   = hold_op_q;
      c_dest = hold_dest_q;
      c_cy   = 1'b0;
      c_ox   = 1'b0;
      c_ovf  = hold_ovf_q;
    end
  end

  // SFR write first, so a same-edge commit overrides only the fields it owns
  always_comb begin
    acc_d       = acc_q;
    b_d         = b_q;
    psw_d       = psw_q;
    br_valid_d  = 1'b0;
    br_target_d = br_target_q;
    if (sfr_we) begin
      case (sfr_sel)
        SFR_ACC: acc_d = sfr_wdata;
        SFR_B:   b_d   = sfr_wdata;
        SFR_PSW: psw_d = sfr_wdata[7:1];
        default: ;
      endcase
    end
    if (commit) begin
      case (c_op)
        OP_ADD, OP_SUB: begin
          acc_d         = c_dest[7:0];
          psw_d[PSW_CY] = c_cy;
          psw_d[PSW_AC] = c_ox;
          psw_d[PSW_OV] = c_ovf;
        end
        OP_MUL: begin
          acc_d         = c_dest[7:0];
          b_d           = c_dest[15:8];
          psw_d[PSW_CY] = 1'b0;
          psw_d[PSW_OV] = c_ovf;
        end
        OP_DIV: begin
          // Divide by zero leaves acc/b alone; dest is meaningless then
          if (!c_ovf) begin
            acc_d = c_dest[15:8];
            b_d   = c_dest[7:0];
          end
          psw_d[PSW_CY] = 1'b0;
          psw_d[PSW_OV] = c_ovf;
        end
        OP_DA, OP_RLC, OP_RRC: begin
          acc_d         = c_dest[7:0];
          psw_d[PSW_CY] = c_cy;
        end
        OP_ANL, OP_ORL, OP_XRL, OP_CPL, OP_RL, OP_RR: acc_d = c_dest[7:0];
        OP_ADDR11, OP_ADDR16: begin
          br_valid_d  = 1'b1;
          br_target_d = c_dest;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= 8'h00;
      b_q         <= 8'h00;
      psw_q       <= RST_SP_PSW[7:1];
      br_valid_q  <= 1'b0;
      br_target_q <= 16'h0000;
      hold_op_q   <= OP_NOP;
      hold_dest_q <= 16'h0000;
      hold_ovf_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      b_q         <= b_d;
      psw_q       <= psw_d;
      br_valid_q  <= br_valid_d;
      br_target_q <= br_target_d;
      if (md_start) begin
        hold_op_q   <= opcode;
        hold_dest_q <= dest;
        hold_ovf_q  <= ovf_in;
      end
    end
  end

  assign acc       = acc_q;
  assign b         = b_q;
  assign psw       = {psw_q, ^acc_q};
  assign br_valid  = br_valid_q;
  assign br_target = br_target_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus random traffic
// compared against a rule-level model of ACC/B/PSW and the branch port.
module tb_alu_writeback;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, cy_in = 1'b0, ox_in = 1'b0, ovf_in = 1'b0, sfr_we = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic [15:0] dest = 16'h0;
  logic [1:0]  sfr_sel = 2'b11;
  logic [7:0]  sfr_wdata = 8'h00;
  logic        in_ready, busy, br_valid;
  logic [7:0]  acc, b, psw;
  logic [15:0] br_target;

  int tests = 0;
  int failed = 0;

  // Reference model state
  logic [7:0]  m_acc, m_b, m_psw;
  logic        m_brv;
  logic [15:0] m_brt;
  bit          m_pend;
  int          m_done_edge, edges;
  logic [3:0]  h_op;
  logic [15:0] h_dest;
  logic        h_ovf;

  always #5 clk = ~clk;

  alu_writeback #(
    .MULDIV_LAT(LAT),
    .RST_SP_PSW(8'h00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .dest     (dest),
    .cy_in    (cy_in),
    .ox_in    (ox_in),
    .ovf_in   (ovf_in),
    .sfr_we   (sfr_we),
    .sfr_sel  (sfr_sel),
    .sfr_wdata(sfr_wdata),
    .acc      (acc),
    .b        (b),
    .psw      (psw),
    .busy     (busy),
    .br_valid (br_valid),
    .br_target(br_target)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".acc"}, {8'h0, acc}, {8'h0, m_acc});
    check({tag, ".b"}, {8'h0, b}, {8'h0, m_b});
    check({tag, ".psw"}, {8'h0, psw}, {8'h0, m_psw[7:1], ^m_acc});
    check({tag, ".br_valid"}, {15'h0, br_valid}, {15'h0, m_brv});
    check({tag, ".br_target"}, br_target, m_brt);
    check({tag, ".in_ready"}, {15'h0, in_ready}, {15'h0, !m_pend});
    check({tag, ".busy"}, {15'h0, busy}, {15'h0, m_pend});
  endtask

  task automatic model_reset();
    m_acc = 8'h00; m_b = 8'h00; m_psw = 8'h00;
    m_brv = 1'b0; m_brt = 16'h0; m_pend = 1'b0;
  endtask

  // Architectural effect of one retired ALU result
  task automatic model_commit(input logic [3:0] op, input logic [15:0] d,
                              input logic cy, input logic ox, input logic ovf);
    case (op)
      4'd1, 4'd2: begin m_acc = d[7:0]; m_psw[7] = cy; m_psw[6] = ox; m_psw[2] = ovf; end
      4'd3: begin m_acc = d[7:0]; m_b = d[15:8]; m_psw[7] = 1'b0; m_psw[2] = ovf; end
      4'd4: begin
        if (!ovf) begin m_acc = d[15:8]; m_b = d[7:0]; end
        m_psw[7] = 1'b0; m_psw[2] = ovf;
      end
      4'd5, 4'd11, 4'd13: begin m_acc = d[7:0]; m_psw[7] = cy; end
      4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12: m_acc = d[7:0];
      4'd14, 4'd15: begin m_brv = 1'b1; m_brt = d; end
      default: ;
    endcase
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check outputs
  task automatic cycle(input string tag, input logic v, input logic [3:0] op,
                       input logic [15:0] d, input logic cy, input logic ox,
                       input logic ovf, input logic we, input logic [1:0] sel,
                       input logic [7:0] wd);
    in_valid = v; opcode = op; dest = d; cy_in = cy; ox_in = ox; ovf_in = ovf;
    sfr_we = we; sfr_sel = sel; sfr_wdata = wd;
    @(posedge clk);
    edges++;
    m_brv = 1'b0;
    if (we) begin
      if (sel == 2'b00) m_acc = wd;
      else if (sel == 2'b01) m_b = wd;
      else if (sel == 2'b10) m_psw = {wd[7:1], 1'b0};
    end
    if (m_pend) begin
      if (edges == m_done_edge) begin
        model_commit(h_op, h_dest, 1'b0, 1'b0, h_ovf);
        m_pend = 1'b0;
      end
    end else if (v) begin
      if ((op == 4'd3 || op == 4'd4) && LAT > 1) begin
        h_op = op; h_dest = d; h_ovf = ovf;
        m_pend = 1'b1;
        m_done_edge = edges + int'(LAT) - 1;
      end else begin
        model_commit(op, d, cy, ox, ovf);
      end
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 8'h00);
  endtask

  initial begin
    edges = 0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // ADD 004F
    cycle("add", 1'b1, 4'd1, 16'h004F, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 8'h00);
    check("add.psw_const", {8'h0, psw}, 16'h0001);

    // MUL with overflow: three busy cycles then commit
    cycle("mul_acc", 1'b1, 4'd3, 16'h0C80, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 8'h00);
    idle("mul_w1");
    idle("mul_w2");
    idle("mul_commit");
    check("mul.acc_const", {8'h0, acc}, 16'h0080);
    check("mul.b_const", {8'h0, b}, 16'h000C);
    check("mul.psw_ov_p", {14'h0, psw[2], psw[0]}, 16'h0003);

    // DIV by zero keeps SFR-preloaded acc/b
    cycle("pre_acc", 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'h55);
    cycle("pre_b", 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 8'hAA);
    cycle("div0", 1'b1, 4'd4, 16'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 8'h00);
    for (int i = 0; i < int'(LAT) - 1; i++) idle("div0_wait");
    check("div0.acc_const", {8'h0, acc}, 16'h0055);
    check("div0.b_const", {8'h0, b}, 16'h00AA);
    check("div0.cy_ov", {14'h0, psw[7], psw[2]}, 16'h0001);

    // ADD merged with PSW SFR write on the same edge
    cycle("add_sfr", 1'b1, 4'd1, 16'h00FF, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 8'h18);
    check("add_sfr.psw_const", {8'h0, psw}, 16'h00D8);

    // Back-to-back branch targets
    cycle("br1", 1'b1, 4'd15, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 8'h00);
    check("br1.target_const", br_target, 16'h1234);
    cycle("br2", 1'b1, 4'd14, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 8'h00);
    check("br2.valid_const", {15'h0, br_valid}, 16'h0001);
    idle("br_end");
    check("br_end.valid_const", {15'h0, br_valid}, 16'h0000);

    // Reset asserted in the middle of a MUL wait
    cycle("mul_rst", 1'b1, 4'd3, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 8'h00);
    idle("mul_rst_w");
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) idle("post_rst");

    // Random traffic, including SFR writes during MUL/DIV waits
    for (int i = 0; i < 300; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0), 2'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
